replay_fsm: RTL and testbench
=============================

REPLAY_FSM -- requirements
Module: replay_fsm

Interface
REQ-001 clk  input  1  single system clock; all state changes on rising edge.
REQ-002 reset_n  input  1  synchronous, active-high reset (asserted = 1), sampled on rising clk.
REQ-003 busy_n  input  1  replay engine status, 0 = replay in progress.
REQ-004 we_i  input  1  write request from transmitter, one-cycle pulse.
REQ-005 to_i  input  1  replay timer timeout, one-cycle pulse.
REQ-006 acknak_i  input  2  DLLP status: 00 none, 01 ACK, 10 NAK, 11 illegal.
REQ-007 rst  output  1  clear/initialise replay buffer.
REQ-008 we_o  output  1  write strobe to replay buffer.
REQ-009 to_o  output  1  timeout-replay strobe to replay buffer.
REQ-010 rdy  output  1  FSM idle, able to accept a new request.
REQ-011 busy_n_o  output  1  0 = replay sequence in progress, upstream must stall.
REQ-012 acknak_o  output  2  registered ACK/NAK command to buffer (01 purge, 10 replay).

Function
REQ-013 States SHALL be: RESET, IDLE, WRITE, ACK, NAK, TIMEOUT, WAIT_BUSY, REPLAY; all outputs SHALL be Moore decodes of the current state register.
REQ-014 RESET: rst=1, all other strobes 0, rdy=0, busy_n_o=1, acknak_o=00; unconditionally -> IDLE next cycle.
REQ-015 IDLE: rdy=1, busy_n_o=1, strobes 0, acknak_o=00.
REQ-016 IDLE input priority, evaluated on one edge: to_i -> TIMEOUT; else acknak_i=10 -> NAK; else acknak_i=01 -> ACK; else we_i -> WRITE; else stay IDLE.
REQ-017 acknak_i=11 SHALL be treated as 00.
REQ-018 WRITE: we_o=1, rdy=0, busy_n_o=1, exactly one cycle, -> IDLE.
REQ-019 ACK: acknak_o=01, rdy=0, busy_n_o=1, exactly one cycle, -> IDLE.
REQ-020 NAK: acknak_o=10, rdy=0, busy_n_o=0, one cycle, -> WAIT_BUSY.
REQ-021 TIMEOUT: to_o=1, rdy=0, busy_n_o=0, one cycle, -> WAIT_BUSY.
REQ-022 WAIT_BUSY: rdy=0, busy_n_o=0; stay while busy_n=1; -> REPLAY on busy_n=0.
REQ-023 REPLAY: rdy=0, busy_n_o=0; stay while busy_n=0; -> IDLE on busy_n=1.
REQ-024 Latency: a request sampled in IDLE at edge N SHALL produce its strobe during cycle N..N+1 (one clock after sampling), width exactly one clock.
REQ-025 Requests (we_i, to_i, acknak_i) arriving outside IDLE SHALL be ignored, not queued; a level held into the next IDLE SHALL be accepted again.
REQ-026 Unused state encodings SHALL recover to RESET on the next edge.

Reset
REQ-027 reset_n=1 at a rising edge SHALL force RESET from any state, including mid-replay, on that edge.
REQ-028 While reset_n stays 1 the FSM SHALL remain in RESET with rst=1; first edge with reset_n=0 -> IDLE.
REQ-029 No output SHALL change except on a rising clk edge.

Verification
REQ-030 Reset held 2 cycles then released -> rst=1 during reset and one cycle after, then rdy=1, busy_n_o=1, strobes 0.
REQ-031 IDLE, we_i pulsed one cycle -> we_o=1 for exactly one cycle one clock later, rdy=0 that cycle, then IDLE.
REQ-032 IDLE, acknak_i=01 one cycle -> acknak_o=01 one cycle, busy_n_o stays 1, back to IDLE; acknak_i=10 held 2 cycles -> acknak_o=10 one cycle only, busy_n_o=0 until busy_n goes 0 then returns 1, then rdy=1.
REQ-033 IDLE, to_i pulse -> to_o=1 one cycle, busy_n_o=0; busy_n low 3 cycles then high -> IDLE on next edge.
REQ-034 Simultaneous to_i=1, acknak_i=10, we_i=1 in IDLE -> only to_o asserted; we_i during REPLAY ignored (no we_o).
REQ-035 reset_n asserted while in REPLAY with busy_n=0 -> RESET on that edge, rst=1, busy_n_o=1.

Source files
------------

// File: rtl/replay_fsm.sv
// Replay-buffer control FSM: sequences write, ACK purge, NAK/timeout replay
// requests into one-clock strobes and holds upstream off while a replay runs.
module replay_fsm (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       busy_n,
  input  logic       we_i,
  input  logic       to_i,
  input  logic [1:0] acknak_i,
  output logic       rst,
  output logic       we_o,
  output logic       to_o,
  output logic       rdy,
  output logic       busy_n_o,
  output logic [1:0] acknak_o
);

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_IDLE      = 3'd1,
    S_WRITE     = 3'd2,
    S_ACK       = 3'd3,
    S_NAK       = 3'd4,
    S_TIMEOUT   = 3'd5,
    S_WAIT_BUSY = 3'd6,
    S_REPLAY    = 3'd7
  } state_t;

  typedef struct packed {
    logic       rst;
    logic       we;
    logic       to;
    logic       rdy;
    logic       busy_n;
    logic [1:0] acknak;
  } outs_t;

  state_t state_r;
  state_t next_state_s;
  outs_t  outs_r;

  // Output word for a given state; registering decode(next) keeps every
  // output an exact Moore image of state_r while coming straight off flops.
  function automatic outs_t decode(input state_t st);
    outs_t o;
    o = '{rst: 1'b0, we: 1'b0, to: 1'b0, rdy: 1'b0, busy_n: 1'b1, acknak: 2'b00};
    case (st)
      S_RESET:     o.rst    = 1'b1;
      S_IDLE:      o.rdy    = 1'b1;
      S_WRITE:     o.we     = 1'b1;
      S_ACK:       o.acknak = 2'b01;
      S_NAK: begin
        o.acknak = 2'b10;
        o.busy_n = 1'b0;
      end
      S_TIMEOUT: begin
        o.to     = 1'b1;
        o.busy_n = 1'b0;
      end
      S_WAIT_BUSY: o.busy_n = 1'b0;
      S_REPLAY:    o.busy_n = 1'b0;
      default:     o.rst    = 1'b1;
    endcase
    return o;
  endfunction

  // Next-state logic; acknak_i=11 matches neither ACK nor NAK and so acts as 00.
  always_comb begin
    next_state_s = S_RESET;
    case (state_r)
      S_RESET: next_state_s = S_IDLE;
      S_IDLE: begin
        if (to_i) begin
          next_state_s = S_TIMEOUT;
        end else if (acknak_i == 2'b10) begin
          next_state_s = S_NAK;
        end else if (acknak_i == 2'b01) begin
          next_state_s = S_ACK;
        end else if (we_i) begin
          next_state_s = S_WRITE;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_WRITE:   next_state_s = S_IDLE;
      S_ACK:     next_state_s = S_IDLE;
      S_NAK:     next_state_s = S_WAIT_BUSY;
      S_TIMEOUT: next_state_s = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (!busy_n) begin
          next_state_s = S_REPLAY;
        end else begin
          next_state_s = S_WAIT_BUSY;
        end
      end
      S_REPLAY: begin
        if (busy_n) begin
          next_state_s = S_IDLE;
        end else begin
          next_state_s = S_REPLAY;
        end
      end
      default: next_state_s = S_RESET;
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_r <= S_RESET;
      outs_r  <= decode(S_RESET);
    end else begin
      state_r <= next_state_s;
      outs_r  <= decode(next_state_s);
    end
  end

  assign rst      = outs_r.rst;
  assign we_o     = outs_r.we;
  assign to_o     = outs_r.to;
  assign rdy      = outs_r.rdy;
  assign busy_n_o = outs_r.busy_n;
  assign acknak_o = outs_r.acknak;

endmodule

// File: tb/tb_replay_fsm.sv
// Self-checking bench for replay_fsm: directed vector table, hand sequences,
// and random stimulus against a behavioural model of the replay protocol.
module tb_replay_fsm;

  logic       clk;
  logic       reset_n;
  logic       busy_n;
  logic       we_i;
  logic       to_i;
  logic [1:0] acknak_i;
  logic       rst;
  logic       we_o;
  logic       to_o;
  logic       rdy;
  logic       busy_n_o;
  logic [1:0] acknak_o;

  int checks;
  int failures;

  replay_fsm dut (
    .clk(clk), .reset_n(reset_n), .busy_n(busy_n), .we_i(we_i), .to_i(to_i),
    .acknak_i(acknak_i), .rst(rst), .we_o(we_o), .to_o(to_o), .rdy(rdy),
    .busy_n_o(busy_n_o), .acknak_o(acknak_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output words {rst, we_o, to_o, rdy, busy_n_o, acknak_o[1:0]}
  localparam logic [6:0] O_RST  = 7'b1000100;
  localparam logic [6:0] O_IDLE = 7'b0001100;
  localparam logic [6:0] O_WR   = 7'b0100100;
  localparam logic [6:0] O_ACK  = 7'b0000101;
  localparam logic [6:0] O_NAK  = 7'b0000010;
  localparam logic [6:0] O_TO   = 7'b0010000;
  localparam logic [6:0] O_BUSY = 7'b0000000;

  typedef struct {
    logic       reset_n;
    logic       busy_n;
    logic       we;
    logic       to;
    logic [1:0] ak;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model: pending reset flag, a one-clock pulse kind, and a
  // replay phase (0 none, 1 awaiting busy low, 2 awaiting busy high).
  bit m_rst;
  int m_pulse;   // 0 none, 1 write, 2 ack, 3 nak, 4 timeout
  int m_phase;

  function automatic logic [6:0] model_out();
    logic [6:0] o;
    o[6]   = m_rst;
    o[5]   = (m_pulse == 1);
    o[4]   = (m_pulse == 4);
    o[3]   = !m_rst && m_pulse == 0 && m_phase == 0;
    o[2]   = !(m_phase != 0 || m_pulse == 3 || m_pulse == 4);
    o[1:0] = (m_pulse == 2) ? 2'b01 : (m_pulse == 3) ? 2'b10 : 2'b00;
    return o;
  endfunction

  task automatic model_step(input logic r, input logic b, input logic w,
                            input logic t, input logic [1:0] a);
    if (r) begin
      m_rst = 1'b1; m_pulse = 0; m_phase = 0;
    end else if (m_rst) begin
      m_rst = 1'b0;
    end else if (m_pulse != 0) begin
      if (m_pulse >= 3) m_phase = 1;
      m_pulse = 0;
    end else if (m_phase == 1) begin
      if (!b) m_phase = 2;
    end else if (m_phase == 2) begin
      if (b) m_phase = 0;
    end else begin
      if (t) m_pulse = 4;
      else if (a == 2'b10) m_pulse = 3;
      else if (a == 2'b01) m_pulse = 2;
      else if (w) m_pulse = 1;
    end
  endtask

  // Apply inputs, clock once, sample 1 time unit after the edge and compare.
  task automatic step_check(input string name, input logic r, input logic b,
                            input logic w, input logic t, input logic [1:0] a,
                            input logic [6:0] exp);
    logic [6:0] act;
    reset_n = r; busy_n = b; we_i = w; to_i = t; acknak_i = a;
    @(posedge clk);
    #1;
    act = {rst, we_o, to_o, rdy, busy_n_o, acknak_o};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic b, input logic w, input logic t,
                     input logic [1:0] a, input logic [6:0] e);
    vec_t v;
    v.reset_n = r; v.busy_n = b; v.we = w; v.to = t; v.ak = a; v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    logic r, b, w, t;
    logic [1:0] a;
    checks = 0; failures = 0;
    reset_n = 1'b1; busy_n = 1'b1; we_i = 1'b0; to_i = 1'b0; acknak_i = 2'b00;

    // Directed table
    add(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, O_RST);
    add(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, O_RST);
    add(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, O_IDLE);
    add(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, O_WR);
    add(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, O_IDLE);
    add(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, O_ACK);
    add(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, O_IDLE);
    add(1'b0, 1'b1, 1'b0, 1'b0, 2'b10, O_NAK);
    add(1'b0, 1'b1, 1'b0, 1'b0, 2'b10, O_BUSY);
    add(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, O_BUSY);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, O_BUSY);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, O_BUSY);
    add(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, O_IDLE);
    add(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, O_TO);
    add(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, O_BUSY);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, O_BUSY);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, O_BUSY);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, O_BUSY);
    add(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, O_IDLE);
    add(1'b0, 1'b1, 1'b1, 1'b1, 2'b10, O_TO);
    add(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, O_BUSY);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, O_BUSY);
    add(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, O_BUSY);
    add(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, O_IDLE);
    add(1'b0, 1'b1, 1'b0, 1'b0, 2'b11, O_IDLE);
    add(1'b0, 1'b1, 1'b1, 1'b0, 2'b11, O_WR);
    add(1'b0, 1'b1, 1'b1, 1'b0, 2'b10, O_IDLE);
    add(1'b0, 1'b1, 1'b1, 1'b0, 2'b10, O_NAK);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, O_BUSY);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, O_BUSY);
    add(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, O_RST);
    add(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, O_IDLE);
    add(1'b0, 1'b1, 1'b1, 1'b0, 2'b01, O_ACK);
    add(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, O_IDLE);

    for (int i = 0; i < vecs.size(); i++) begin
      step_check($sformatf("vec%0d", i), vecs[i].reset_n, vecs[i].busy_n,
                 vecs[i].we, vecs[i].to, vecs[i].ak, vecs[i].exp);
    end

    // Held we_i alternates WRITE / IDLE: each IDLE re-accepts the level
    for (int i = 0; i < 3; i++) begin
      step_check("held_we_wr", 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, O_WR);
      step_check("held_we_idle", 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, O_IDLE);
    end
    // Long WAIT_BUSY stall ignoring requests, then reset out of it
    step_check("to_long", 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, O_TO);
    for (int i = 0; i < 5; i++) begin
      step_check("wait_stall", 1'b0, 1'b1, 1'b1, 1'b1, 2'b01, O_BUSY);
    end
    step_check("wait_reset", 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, O_RST);
    step_check("wait_reset_hold", 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, O_RST);
    step_check("wait_reset_exit", 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, O_IDLE);

    // Randomised run against the behavioural model
    m_rst = 1'b1; m_pulse = 0; m_phase = 0;
    for (int i = 0; i < 2000; i++) begin
      r = (i == 0) ? 1'b1 : ($urandom_range(0, 49) == 0);
      b = ($urandom_range(0, 3) != 0) ? busy_n : ~busy_n;
      w = ($urandom_range(0, 3) == 0);
      t = ($urandom_range(0, 9) == 0);
      a = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      model_step(r, b, w, t, a);
      step_check("rand", r, b, w, t, a, model_out());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
